// File: rtl/operand_pair.sv
// Byte-stream pairing stage: collects two bytes into an operand pair and
// buffers pairs in a 2-entry FIFO feeding the downstream ADD/SUB stage.
module operand_pair #(
  parameter bit SWAP = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  in_data_i,
  input  logic        in_valid_i,
  output logic        in_ready_o,
  input  logic        flush_i,
  output logic [7:0]  out_a_o,
  output logic [7:0]  out_b_o,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic [15:0] pair_cnt_o
);

  typedef enum logic {
    EMPTY = 1'b0,
    HALF  = 1'b1
  } state_e;

  state_e      state_q;
  logic [7:0]  hold_q;
  logic [7:0]  fa_q [2];
  logic [7:0]  fb_q [2];
  logic        rd_q;
  logic        wr_q;
  logic [1:0]  cnt_q;
  logic [1:0]  cnt_d;
  logic [15:0] pair_cnt_q;
  logic [15:0] pair_cnt_d;

  logic        in_hs;
  logic        push;
  logic        pop;
  logic [7:0]  pa;
  logic [7:0]  pb;

  always_comb begin
    in_ready_o = (state_q == EMPTY) || (cnt_q != 2'd2);
    in_hs      = in_valid_i && in_ready_o;
    push       = in_hs && (state_q == HALF) && !flush_i;
    pop        = (cnt_q != 2'd0) && out_ready_i;
    pa         = SWAP ? in_data_i : hold_q;
    pb         = SWAP ? hold_q : in_data_i;
    cnt_d      = cnt_q;
    if (push && !pop) cnt_d = cnt_q + 2'd1;
    if (pop && !push) cnt_d = cnt_q - 2'd1;
    pair_cnt_d = pair_cnt_q;
    if (pop) pair_cnt_d = pair_cnt_q + 16'd1;
  end

  // Pairing FSM; a flush wins over any byte accepted in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      hold_q  <= 8'h00;
    end else if (flush_i) begin
      state_q <= EMPTY;
    end else if (in_hs) begin
      unique case (state_q)
        EMPTY: begin
          hold_q  <= in_data_i;
          state_q <= HALF;
        end
        HALF: state_q <= EMPTY;
        default: state_q <= EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        fa_q[i] <= 8'h00;
        fb_q[i] <= 8'h00;
      end
      rd_q       <= 1'b0;
      wr_q       <= 1'b0;
      cnt_q      <= 2'd0;
      pair_cnt_q <= 16'h0000;
    end else begin
      if (push) begin
        fa_q[wr_q] <= pa;
        fb_q[wr_q] <= pb;
        wr_q       <= ~wr_q;
      end
      if (pop) rd_q <= ~rd_q;
      cnt_q      <= cnt_d;
      pair_cnt_q <= pair_cnt_d;
    end
  end

  assign out_valid_o = (cnt_q != 2'd0);
  assign out_a_o     = fa_q[rd_q];
  assign out_b_o     = fb_q[rd_q];
  assign pair_cnt_o  = pair_cnt_q;

endmodule

// File: tb/tb_operand_pair.sv
// Directed bench for operand_pair: pairing, swap, backpressure, flush,
// asynchronous reset and pair counter wrap.
module tb_operand_pair;

  logic        clk;
  logic        rst_n;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        flush;
  logic        out_ready;
  logic        in_ready;
  logic [7:0]  out_a;
  logic [7:0]  out_b;
  logic        out_valid;
  logic [15:0] pair_cnt;
  logic        s_in_ready;
  logic [7:0]  s_out_a;
  logic [7:0]  s_out_b;
  logic        s_out_valid;
  logic [15:0] s_pair_cnt;

  int tests;
  int fails;

  operand_pair #(.SWAP(1'b0)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_data_i   (in_data),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .flush_i     (flush),
    .out_a_o     (out_a),
    .out_b_o     (out_b),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .pair_cnt_o  (pair_cnt)
  );

  operand_pair #(.SWAP(1'b1)) dut_s (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_data_i   (in_data),
    .in_valid_i  (in_valid),
    .in_ready_o  (s_in_ready),
    .flush_i     (flush),
    .out_a_o     (s_out_a),
    .out_b_o     (s_out_b),
    .out_valid_o (s_out_valid),
    .out_ready_i (out_ready),
    .pair_cnt_o  (s_pair_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset;
    rst_n = 1'b0; in_data = 8'h00; in_valid = 1'b0;
    flush = 1'b0; out_ready = 1'b0;
    #12;
    tests++;
    if (out_valid !== 1'b0 || out_a !== 8'h00 || out_b !== 8'h00) begin
      fails++;
      $display("FAIL reset_out: v=%b a=%h b=%h, want 0 00 00",
               out_valid, out_a, out_b);
    end
    tests++;
    if (pair_cnt !== 16'h0000 || in_ready !== 1'b1) begin
      fails++;
      $display("FAIL reset_cnt: cnt=%h rdy=%b, want 0000 1",
               pair_cnt, in_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_basic;
    out_ready = 1'b1;
    @(negedge clk); in_data = 8'h12; in_valid = 1'b1;
    @(negedge clk); in_data = 8'h34;
    @(negedge clk); in_valid = 1'b0;
    tests++;
    if (out_valid !== 1'b1 || out_a !== 8'h12 || out_b !== 8'h34) begin
      fails++;
      $display("FAIL basic_pair: v=%b a=%h b=%h, want 1 12 34",
               out_valid, out_a, out_b);
    end
    tests++;
    if (s_out_a !== 8'h34 || s_out_b !== 8'h12) begin
      fails++;
      $display("FAIL basic_swap: a=%h b=%h, want 34 12", s_out_a, s_out_b);
    end
    @(negedge clk);
    tests++;
    if (pair_cnt !== 16'd1 || out_valid !== 1'b0) begin
      fails++;
      $display("FAIL basic_cnt: cnt=%h v=%b, want 0001 0",
               pair_cnt, out_valid);
    end
  endtask

  task automatic test_swap;
    out_ready = 1'b1;
    @(negedge clk); in_data = 8'hAA; in_valid = 1'b1;
    @(negedge clk); in_data = 8'h55;
    @(negedge clk); in_valid = 1'b0;
    tests++;
    if (s_out_valid !== 1'b1 || s_out_a !== 8'h55 || s_out_b !== 8'hAA) begin
      fails++;
      $display("FAIL swap_pair: v=%b a=%h b=%h, want 1 55 AA",
               s_out_valid, s_out_a, s_out_b);
    end
    @(negedge clk);
    tests++;
    if (pair_cnt !== 16'd2) begin
      fails++;
      $display("FAIL swap_cnt: cnt=%h, want 0002", pair_cnt);
    end
  endtask

  task automatic test_backpressure;
    logic [7:0] ea [3];
    logic [7:0] eb [3];
    ea[0] = 8'h01; eb[0] = 8'h02;
    ea[1] = 8'h03; eb[1] = 8'h04;
    ea[2] = 8'h05; eb[2] = 8'h06;
    out_ready = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      in_data = 8'(i); in_valid = 1'b1;
      tests++;
      if (in_ready !== 1'b1) begin
        fails++;
        $display("FAIL bp_accept%0d: rdy=%b, want 1", i, in_ready);
      end
    end
    @(negedge clk); in_data = 8'h06;
    @(negedge clk);
    @(negedge clk);
    tests++;
    if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
      fails++;
      $display("FAIL bp_full: rdy=%b v=%b, want 0 1", in_ready, out_valid);
    end
    tests++;
    if (out_a !== 8'h01 || out_b !== 8'h02) begin
      fails++;
      $display("FAIL bp_stable: a=%h b=%h, want 01 02", out_a, out_b);
    end
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      if (k > 0) begin
        tests++;
        if (out_valid !== 1'b1 || out_a !== ea[k] || out_b !== eb[k]) begin
          fails++;
          $display("FAIL bp_order%0d: v=%b a=%h b=%h, want 1 %h %h",
                   k, out_valid, out_a, out_b, ea[k], eb[k]);
        end
      end
      @(negedge clk);
      if (k == 1) in_valid = 1'b0;
    end
    tests++;
    if (out_valid !== 1'b0 || pair_cnt !== 16'd5) begin
      fails++;
      $display("FAIL bp_drain: v=%b cnt=%h, want 0 0005",
               out_valid, pair_cnt);
    end
  endtask

  task automatic test_flush;
    out_ready = 1'b1;
    @(negedge clk); in_data = 8'h77; in_valid = 1'b1;
    @(negedge clk); in_valid = 1'b0; flush = 1'b1;
    @(negedge clk); flush = 1'b0; in_data = 8'h10; in_valid = 1'b1;
    @(negedge clk); in_data = 8'h20;
    @(negedge clk); in_valid = 1'b0;
    tests++;
    if (out_valid !== 1'b1 || out_a !== 8'h10 || out_b !== 8'h20) begin
      fails++;
      $display("FAIL flush_pair: v=%b a=%h b=%h, want 1 10 20",
               out_valid, out_a, out_b);
    end
    @(negedge clk);
    tests++;
    if (out_valid !== 1'b0 || pair_cnt !== 16'd6) begin
      fails++;
      $display("FAIL flush_drain: v=%b cnt=%h, want 0 0006",
               out_valid, pair_cnt);
    end
    // second byte accepted together with flush must vanish
    @(negedge clk); in_data = 8'h33; in_valid = 1'b1;
    @(negedge clk); in_data = 8'h44; flush = 1'b1;
    @(negedge clk); in_valid = 1'b0; flush = 1'b0;
    tests++;
    if (out_valid !== 1'b0 || pair_cnt !== 16'd6) begin
      fails++;
      $display("FAIL flush_same: v=%b cnt=%h, want 0 0006",
               out_valid, pair_cnt);
    end
  endtask

  task automatic test_reset_mid;
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); in_data = 8'hC0 + 8'(i); in_valid = 1'b1;
    end
    @(negedge clk); in_valid = 1'b0;
    tests++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
      fails++;
      $display("FAIL rst_pre: v=%b rdy=%b, want 1 0", out_valid, in_ready);
    end
    #2 rst_n = 1'b0;
    #1;
    tests++;
    if (out_valid !== 1'b0 || pair_cnt !== 16'h0000 || in_ready !== 1'b1) begin
      fails++;
      $display("FAIL rst_async: v=%b cnt=%h rdy=%b, want 0 0000 1",
               out_valid, pair_cnt, in_ready);
    end
    @(negedge clk); rst_n = 1'b1; out_ready = 1'b1;
    @(negedge clk); in_data = 8'h09; in_valid = 1'b1;
    @(negedge clk); in_data = 8'h0A;
    @(negedge clk); in_valid = 1'b0;
    tests++;
    if (out_valid !== 1'b1 || out_a !== 8'h09 || out_b !== 8'h0A) begin
      fails++;
      $display("FAIL rst_pair: v=%b a=%h b=%h, want 1 09 0A",
               out_valid, out_a, out_b);
    end
    @(negedge clk);
    tests++;
    if (out_valid !== 1'b0 || pair_cnt !== 16'd1) begin
      fails++;
      $display("FAIL rst_after: v=%b cnt=%h, want 0 0001",
               out_valid, pair_cnt);
    end
  endtask

  task automatic test_wrap;
    out_ready = 1'b1;
    @(negedge clk);
    force dut.pair_cnt_q = 16'hFFFE;
    #1 release dut.pair_cnt_q;
    for (int n = 0; n < 2; n++) begin
      @(negedge clk); in_data = 8'hE0; in_valid = 1'b1;
      @(negedge clk); in_data = 8'hE1;
      @(negedge clk); in_valid = 1'b0;
      @(negedge clk);
      tests++;
      if (n == 0 && pair_cnt !== 16'hFFFF) begin
        fails++;
        $display("FAIL wrap_max: cnt=%h, want FFFF", pair_cnt);
      end
      if (n == 1 && pair_cnt !== 16'h0000) begin
        fails++;
        $display("FAIL wrap_zero: cnt=%h, want 0000", pair_cnt);
      end
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    test_reset();
    test_basic();
    test_swap();
    test_backpressure();
    test_flush();
    test_reset_mid();
    test_wrap();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/operand_pair.md
OPERAND_PAIR -- requirements
Module: operand_pair

Interface
REQ-001 Parameter SWAP, default 0: 0 = first byte of a pair goes to OUT_A and second to OUT_B; 1 = first byte to OUT_B and second to OUT_A.
REQ-002 CLK  input  1  single clock; all state updates on its rising edge.
REQ-003 RST_N  input  1  reset, asynchronous assert, active-low.
REQ-004 IN_DATA  input  8  byte stream from upstream.
REQ-005 IN_VALID  input  1  IN_DATA valid.
REQ-006 IN_READY  output  1  block accepts IN_DATA this cycle.
REQ-007 FLUSH  input  1  synchronous; discards a held first byte.
REQ-008 OUT_A  output  8  operand A to downstream ADD/SUB stage (DIN_A).
REQ-009 OUT_B  output  8  operand B to downstream ADD/SUB stage (DIN_B).
REQ-010 OUT_VALID  output  1  OUT_A/OUT_B hold a valid pair.
REQ-011 OUT_READY  input  1  downstream consumes the pair this cycle.
REQ-012 PAIR_CNT  output  16  number of pairs delivered since reset.

Function
REQ-013 An input handshake SHALL occur on a rising edge where IN_VALID=1 and IN_READY=1; an output handshake where OUT_VALID=1 and OUT_READY=1.
REQ-014 Pairing FSM SHALL have two states: EMPTY (no byte held) and HALF (first byte held in an internal register).
REQ-015 In EMPTY, an input handshake SHALL store IN_DATA as the first byte and transition to HALF.
REQ-016 In HALF, an input handshake SHALL push {first, IN_DATA} (mapped per SWAP) into the pair FIFO and transition to EMPTY.
REQ-017 The pair FIFO SHALL be 2 entries deep, first-in first-out, with 2-bit occupancy count 0..2.
REQ-018 IN_READY SHALL be 1 in EMPTY and, in HALF, 1 only when the FIFO count is less than 2; IN_READY SHALL NOT depend combinationally on OUT_READY.
REQ-019 OUT_VALID SHALL be 1 when FIFO count is nonzero; OUT_A/OUT_B SHALL show the FIFO head; latency from the second-byte handshake to OUT_VALID=1 with an empty FIFO is 1 cycle.
REQ-020 OUT_A/OUT_B SHALL hold a stable value while OUT_VALID=1 and OUT_READY=0.
REQ-021 A simultaneous push and pop SHALL leave the count unchanged and preserve order, including at count=2 (no push possible then per REQ-018) and count=1.
REQ-022 A pop from count=1 with no push SHALL give count=0 and OUT_VALID=0 the next cycle; OUT_A/OUT_B values are don't-care while OUT_VALID=0.
REQ-023 FLUSH=1 SHALL force the FSM to EMPTY at the next edge; any input handshake in the same cycle SHALL be consumed and discarded; FIFO contents and PAIR_CNT are unaffected.
REQ-024 PAIR_CNT SHALL increment by 1 on each output handshake and wrap from 0xFFFF to 0x0000.
REQ-025 The block SHALL contain no arithmetic on the operands; bytes pass bit-exact.

Reset
REQ-026 While RST_N=0: FSM=EMPTY, FIFO count=0, OUT_VALID=0, OUT_A=0x00, OUT_B=0x00, PAIR_CNT=0x0000, held byte=0x00, IN_READY=1.
REQ-027 Reset asserted mid-pair or with a full FIFO SHALL discard all held data immediately (asynchronous); operation resumes on the first rising edge after RST_N returns to 1.

Verification
REQ-028 SWAP=0, OUT_READY=1: bytes 0x12, 0x34 on consecutive cycles -> one cycle after the 0x34 handshake, OUT_VALID=1, OUT_A=0x12, OUT_B=0x34; PAIR_CNT=1 after the following edge.
REQ-029 SWAP=1: bytes 0xAA, 0x55 -> OUT_A=0x55, OUT_B=0xAA.
REQ-030 OUT_READY=0, stream 0x01..0x06 continuous -> pairs (01,02), (03,04) buffered, 0x05 held, IN_READY=0 with 0x06 pending; raise OUT_READY -> pairs emerge in order (01,02), (03,04), (05,06) with no loss or duplication.
REQ-031 Send 0x77, then FLUSH=1 for one cycle, then 0x10, 0x20 -> only pair (0x10,0x20) emerges; 0x77 never appears.
REQ-032 Assert RST_N=0 for one cycle while HALF with 2 pairs buffered -> OUT_VALID=0 and PAIR_CNT=0 immediately; new bytes 0x09, 0x0A then yield exactly one pair (0x09,0x0A).
REQ-033 Preload 65535 output handshakes, then one more -> PAIR_CNT reads 0xFFFF, then 0x0000.
